// File: rtl/oruntu_verici.sv
// Serial pattern transmitter: loads a word of programmable length and shifts it out MSB-first.
// Optional even-parity trailer bit is enabled by defining ORUNTU_PARITE_EN.
module oruntu_verici #(
    parameter int GENISLIK = 8,
    parameter int UW       = $clog2(GENISLIK+1)
) (
    input  logic                saat,
    input  logic                reset,
    input  logic                baslat,
    input  logic [GENISLIK-1:0] veri,
    input  logic [UW-1:0]       uzunluk,
    output logic                hazir,
    output logic                cikis,
    output logic                gecerli,
    output logic                bitti
);

    typedef enum logic [1:0] {
        BOS,
`ifdef ORUNTU_PARITE_EN
        PARITE,
`endif
        GONDER
    } durum_t;

    localparam logic [UW-1:0] W_GEN = UW'(GENISLIK);

    durum_t              r_durum;
    logic [GENISLIK-1:0] r_kaydirici;
    logic [UW-1:0]       r_sayac;
    logic                r_cikis;
    logic                r_gecerli;
    logic                r_hazir;
    logic                r_bitti;
`ifdef ORUNTU_PARITE_EN
    logic                r_parite;
`endif

    logic [UW-1:0]       w_uzunluk;
    logic [GENISLIK-1:0] w_hizali;

    // Zero or oversized lengths both mean a full-width word.
    assign w_uzunluk = (uzunluk == '0 || uzunluk > W_GEN) ? W_GEN : uzunluk;
    assign w_hizali  = veri << (W_GEN - w_uzunluk);

    assign hazir   = r_hazir;
    assign cikis   = r_cikis;
    assign gecerli = r_gecerli;
    assign bitti   = r_bitti;

    // r_cikis holds the bit on the line; r_kaydirici holds the bits still to come.
    always_ff @(posedge saat or posedge reset) begin
        if (reset) begin
            r_durum     <= BOS;
            r_kaydirici <= '0;
            r_sayac     <= '0;
            r_cikis     <= 1'b0;
            r_gecerli   <= 1'b0;
            r_hazir     <= 1'b1;
            r_bitti     <= 1'b0;
`ifdef ORUNTU_PARITE_EN
            r_parite    <= 1'b0;
`endif
        end else begin
            r_bitti <= 1'b0;
            case (r_durum)
                BOS: begin
                    r_cikis   <= 1'b0;
                    r_gecerli <= 1'b0;
                    r_hazir   <= 1'b1;
                    if (baslat) begin
                        r_durum     <= GONDER;
                        r_cikis     <= w_hizali[GENISLIK-1];
                        r_kaydirici <= w_hizali << 1;
                        r_sayac     <= w_uzunluk;
                        r_gecerli   <= 1'b1;
                        r_hazir     <= 1'b0;
`ifdef ORUNTU_PARITE_EN
                        r_parite    <= w_hizali[GENISLIK-1];
`endif
                    end
                end
                GONDER: begin
                    if (r_sayac == UW'(1)) begin
                        r_sayac <= '0;
`ifdef ORUNTU_PARITE_EN
                        r_durum <= PARITE;
                        r_cikis <= r_parite;
`else
                        r_durum   <= BOS;
                        r_cikis   <= 1'b0;
                        r_gecerli <= 1'b0;
                        r_hazir   <= 1'b1;
                        r_bitti   <= 1'b1;
`endif
                    end else begin
                        r_cikis     <= r_kaydirici[GENISLIK-1];
                        r_kaydirici <= r_kaydirici << 1;
                        r_sayac     <= r_sayac - UW'(1);
`ifdef ORUNTU_PARITE_EN
                        r_parite    <= r_parite ^ r_kaydirici[GENISLIK-1];
`endif
                    end
                end
`ifdef ORUNTU_PARITE_EN
                PARITE: begin
                    r_durum   <= BOS;
                    r_cikis   <= 1'b0;
                    r_gecerli <= 1'b0;
                    r_hazir   <= 1'b1;
                    r_bitti   <= 1'b1;
                end
`endif
                default: r_durum <= BOS;
            endcase
        end
    end

endmodule

// File: tb/tb_oruntu_verici.sv
// Directed bench for oruntu_verici: each cycle compares {hazir,gecerli,cikis,bitti}.
module tb_oruntu_verici;

    logic       saat = 1'b0;
    logic       reset;
    logic       baslat;
    logic [7:0] veri;
    logic [3:0] uzunluk;
    logic       hazir, cikis, gecerli, bitti;

    int total = 0;
    int bad   = 0;

    oruntu_verici #(.GENISLIK(8)) dut (
        .saat    (saat),
        .reset   (reset),
        .baslat  (baslat),
        .veri    (veri),
        .uzunluk (uzunluk),
        .hazir   (hazir),
        .cikis   (cikis),
        .gecerli (gecerli),
        .bitti   (bitti)
    );

    always #5 saat = ~saat;

    task automatic adim();
        @(posedge saat);
        #1;
    endtask

    task automatic kontrol(input string tag, input logic [3:0] beklenen);
        logic [3:0] gozlenen;
        gozlenen = {hazir, gecerli, cikis, bitti};
        total++;
        assert (gozlenen === beklenen)
        else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b (hazir,gecerli,cikis,bitti)", tag, gozlenen, beklenen);
        end
    endtask

    // Accept a word; returns with its first bit on the line.
    task automatic bas(input logic [7:0] v, input logic [3:0] u);
        veri    = v;
        uzunluk = u;
        baslat  = 1'b1;
        adim();
        baslat  = 1'b0;
    endtask

    // Check L data bits (pattern MSB-first in the low L bits), optional parity, then the bitti cycle.
    task automatic kelime(input string tag, input logic [7:0] desen, input int L, input logic par);
        logic [7:0] d;
        d = desen;
        for (int i = 0; i < L; i++) begin
            kontrol(tag, {1'b0, 1'b1, d[L-1-i], 1'b0});
            adim();
        end
`ifdef ORUNTU_PARITE_EN
        kontrol({tag, "_par"}, {1'b0, 1'b1, par, 1'b0});
        adim();
`else
        if (par === 1'bx) kontrol({tag, "_x"}, 4'b0000);
`endif
        kontrol({tag, "_bitti"}, 4'b1001);
    endtask

    initial begin
        reset   = 1'b1;
        baslat  = 1'b0;
        veri    = 8'h00;
        uzunluk = 4'd0;
        adim();
        adim();
        kontrol("reset_state", 4'b1000);
        reset = 1'b0;

        for (int i = 0; i < 20; i++) begin
            adim();
            kontrol("idle", 4'b1000);
        end

        bas(8'b1111_0001, 4'd0);
        kelime("basic", 8'b1111_0001, 8, 1'b1);
        adim();
        kontrol("basic_after", 4'b1000);

        bas(8'hA5, 4'd3);
        kelime("short3", 8'b0000_0101, 3, 1'b0);
        adim();
        kontrol("short3_after", 4'b1000);

        bas(8'hA5, 4'd12);
        kelime("clamp12", 8'hA5, 8, 1'b0);
        adim();

        bas(8'hF1, 4'd0);
        veri    = 8'h00;
        uzunluk = 4'd3;
        kelime("midchange", 8'hF1, 8, 1'b1);
        adim();
        kontrol("midchange_after", 4'b1000);

        veri    = 8'h3C;
        uzunluk = 4'd4;
        baslat  = 1'b1;
        adim();
        for (int w = 0; w < 5; w++) begin
            kelime("repeat", 8'b0000_1100, 4, 1'b0);
            if (w == 4) baslat = 1'b0;
            adim();
        end
        kontrol("repeat_after", 4'b1000);

        bas(8'hF1, 4'd0);
        for (int i = 0; i < 3; i++) begin
            kontrol("abort_pre", 4'b0110);
            adim();
        end
        kontrol("abort_bit4", 4'b0110);
        #2;
        reset = 1'b1;
        #1;
        kontrol("abort_immediate", 4'b1000);
        adim();
        kontrol("abort_held", 4'b1000);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            adim();
            kontrol("abort_nobitti", 4'b1000);
        end

        bas(8'h07, 4'd0);
        kelime("w07", 8'h07, 8, 1'b1);
        adim();

        bas(8'b0000_0011, 4'd3);
        kelime("w011", 8'b0000_0011, 3, 1'b0);
        adim();
        kontrol("final_idle", 4'b1000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
